// File: rtl/plic_irq_dispatch.sv
// Purpose: core-side PLIC interrupt dispatcher; settles, reads MVEC/MARG, issues a trap request and waits for mret.
// Latency: irq_req_o rises SETTLE_CYCLES+3 cycles after the qualifying irq_valid_i && global_ie_i edge.
// Backpressure: irq_req_o is held with stable vec/arg until irq_ack_i; a mstatus.MIE drop withdraws it; no new dispatch until mret_i.
//
// Ports:
//   clk, rst_n                    core clock, async active-low reset
//   irq_valid_i, global_ie_i      PLIC irq_valid level and mstatus.MIE
//   plic_rd_o, plic_raddr_o       PLIC read port ownership and address (state-decoded)
//   plic_rdata_i                  PLIC read data, returned in the same cycle as the address
//   irq_req_o, irq_vec_o,         trap request, captured handler entry and argument
//   irq_arg_o, irq_ack_i          and pipeline acknowledge
//   mret_i                        one-cycle pulse when the handler retires mret
//   busy_o                        dispatcher is not idle
//   stat_taken_o, stat_spurious_o saturating ack / spurious-drop counters, present only
//                                 when PLIC_DISPATCH_STATS_EN is defined
module plic_irq_dispatch #(
    parameter int                           SETTLE_CYCLES       = 3,
    parameter int                           PLIC_AXI_ADDR_WIDTH = 32,
    parameter int                           PLIC_AXI_DATA_WIDTH = 32,
    parameter logic [PLIC_AXI_ADDR_WIDTH-1:0] PLIC_INT_MVEC_ADDR = 'h100,
    parameter logic [PLIC_AXI_ADDR_WIDTH-1:0] PLIC_INT_MARG_ADDR = 'h104
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           irq_valid_i,
    input  logic                           global_ie_i,
    output logic                           plic_rd_o,
    output logic [PLIC_AXI_ADDR_WIDTH-1:0] plic_raddr_o,
    input  logic [PLIC_AXI_DATA_WIDTH-1:0] plic_rdata_i,
    output logic                           irq_req_o,
    output logic [31:0]                    irq_vec_o,
    output logic [31:0]                    irq_arg_o,
    input  logic                           irq_ack_i,
    input  logic                           mret_i,
    output logic                           busy_o
`ifdef PLIC_DISPATCH_STATS_EN
    ,
    output logic [15:0]                    stat_taken_o,
    output logic [15:0]                    stat_spurious_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_RD_VEC,
        S_RD_ARG,
        S_REQ,
        S_SERVICE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] vec_q, vec_d;
    logic [31:0] arg_q, arg_d;

    // A drop of either qualifier while settling means the PLIC output was not stable.
    logic spurious_drop;
    assign spurious_drop = (state_q == S_SETTLE) && !(irq_valid_i && global_ie_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        arg_d   = arg_q;
        case (state_q)
            S_IDLE: begin
                if (irq_valid_i && global_ie_i) begin
                    cnt_d   = CNT_INIT;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (spurious_drop) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RD_VEC;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RD_VEC: begin
                vec_d   = plic_rdata_i[31:0];
                state_d = S_RD_ARG;
            end
            S_RD_ARG: begin
                arg_d   = plic_rdata_i[31:0];
                state_d = S_REQ;
            end
            S_REQ: begin
                // Ack has priority over a same-cycle MIE drop: the trap is already taken.
                if (irq_ack_i) begin
                    state_d = S_SERVICE;
                end else if (!global_ie_i) begin
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (mret_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            vec_q   <= 32'd0;
            arg_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            arg_q   <= arg_d;
        end
    end

    // All outputs decode from flops only, so no input-to-output combinational path exists.
    always_comb begin
        plic_raddr_o = '0;
        case (state_q)
            S_RD_VEC: plic_raddr_o = PLIC_INT_MVEC_ADDR;
            S_RD_ARG: plic_raddr_o = PLIC_INT_MARG_ADDR;
            default:  plic_raddr_o = '0;
        endcase
    end

    assign plic_rd_o = (state_q == S_RD_VEC) || (state_q == S_RD_ARG);
    assign irq_req_o = (state_q == S_REQ);
    assign busy_o    = (state_q != S_IDLE);
    assign irq_vec_o = vec_q;
    assign irq_arg_o = arg_q;

`ifdef PLIC_DISPATCH_STATS_EN
    logic [15:0] taken_q, taken_d;
    logic [15:0] spur_q, spur_d;

    always_comb begin
        taken_d = taken_q;
        spur_d  = spur_q;
        if ((state_q == S_REQ) && irq_ack_i && (taken_q != 16'hFFFF)) begin
            taken_d = taken_q + 16'd1;
        end
        if (spurious_drop && (spur_q != 16'hFFFF)) begin
            spur_d = spur_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q <= 16'd0;
            spur_q  <= 16'd0;
        end else begin
            taken_q <= taken_d;
            spur_q  <= spur_d;
        end
    end

    assign stat_taken_o    = taken_q;
    assign stat_spurious_o = spur_q;
`endif

endmodule

// File: tb/tb_plic_irq_dispatch.sv
// Bench for plic_irq_dispatch: a PLIC read-port model, a queue of expected
// (vec, arg) pairs pushed when an interrupt is raised and popped when irq_req_o
// appears, and one task per scenario. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_plic_irq_dispatch;

    localparam int          S      = 3;
    localparam logic [31:0] A_MVEC = 32'h0000_0100;
    localparam logic [31:0] A_MARG = 32'h0000_0104;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        irq_valid_i, global_ie_i, irq_ack_i, mret_i;
    logic        plic_rd_o, irq_req_o, busy_o;
    logic [31:0] plic_raddr_o, plic_rdata_i, irq_vec_o, irq_arg_o;
`ifdef PLIC_DISPATCH_STATS_EN
    logic [15:0] stat_taken_o, stat_spurious_o;
`endif

    plic_irq_dispatch #(
        .SETTLE_CYCLES      (S),
        .PLIC_AXI_ADDR_WIDTH(32),
        .PLIC_AXI_DATA_WIDTH(32),
        .PLIC_INT_MVEC_ADDR (A_MVEC),
        .PLIC_INT_MARG_ADDR (A_MARG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_valid_i (irq_valid_i),
        .global_ie_i (global_ie_i),
        .plic_rd_o   (plic_rd_o),
        .plic_raddr_o(plic_raddr_o),
        .plic_rdata_i(plic_rdata_i),
        .irq_req_o   (irq_req_o),
        .irq_vec_o   (irq_vec_o),
        .irq_arg_o   (irq_arg_o),
        .irq_ack_i   (irq_ack_i),
        .mret_i      (mret_i),
        .busy_o      (busy_o)
`ifdef PLIC_DISPATCH_STATS_EN
        ,
        .stat_taken_o   (stat_taken_o),
        .stat_spurious_o(stat_spurious_o)
`endif
    );

    always #5 clk = ~clk;

    // PLIC register model: combinational read, garbage for unmapped accesses.
    logic [31:0] mvec_m, marg_m;
    always_comb begin
        plic_rdata_i = 32'hDEAD_BEEF;
        if (plic_rd_o && plic_raddr_o == A_MVEC) plic_rdata_i = mvec_m;
        else if (plic_rd_o && plic_raddr_o == A_MARG) plic_rdata_i = marg_m;
    end

    typedef struct packed {
        logic [31:0] vec;
        logic [31:0] arg;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int exp_taken = 0;
    int exp_spur = 0;

    task automatic step();
        @(negedge clk);
    endtask

    // Wait (bounded) for irq_req_o, then pop and compare the expected pair.
    task automatic wait_req(input int budget, output int lat);
        exp_t e;
        lat = 0;
        while (!irq_req_o && lat < budget) begin
            step();
            lat++;
        end
        checks++;
        if (irq_req_o !== 1'b1) begin
            failures++;
            $display("FAIL req_timeout: irq_req_o=%0b required 1 within %0d cycles", irq_req_o, budget);
        end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: irq_req_o=1 with no expected dispatch queued");
        end else begin
            e = sb.pop_front();
            checks++;
            if (irq_vec_o !== e.vec) begin
                failures++;
                $display("FAIL req_vec: got %h required %h", irq_vec_o, e.vec);
            end
            checks++;
            if (irq_arg_o !== e.arg) begin
                failures++;
                $display("FAIL req_arg: got %h required %h", irq_arg_o, e.arg);
            end
        end
    endtask

    // Raise the source and reach REQ, checking the nominal latency.
    task automatic run_to_req(input logic [31:0] v, input logic [31:0] a);
        int lat;
        mvec_m = v;
        marg_m = a;
        sb.push_back('{vec: v, arg: a});
        irq_valid_i = 1'b1;
        global_ie_i = 1'b1;
        wait_req(S + 6, lat);
        checks++;
        if (lat != S + 3) begin
            failures++;
            $display("FAIL req_latency: got %0d required %0d", lat, S + 3);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        irq_valid_i = 1'b0; global_ie_i = 1'b0; irq_ack_i = 1'b0; mret_i = 1'b0;
        mvec_m = 32'h0; marg_m = 32'h0;
        step(); step();
        checks++;
        if ({irq_req_o, busy_o, plic_rd_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: req/busy/rd=%b required 000", {irq_req_o, busy_o, plic_rd_o});
        end
        checks++;
        if ({plic_raddr_o, irq_vec_o, irq_arg_o} !== 96'd0) begin
            failures++;
            $display("FAIL reset_data: raddr=%h vec=%h arg=%h required 0", plic_raddr_o, irq_vec_o, irq_arg_o);
        end
`ifdef PLIC_DISPATCH_STATS_EN
        checks++;
        if ({stat_taken_o, stat_spurious_o} !== 32'd0) begin
            failures++;
            $display("FAIL reset_stats: taken=%0d spurious=%0d required 0", stat_taken_o, stat_spurious_o);
        end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic exp_rd;
        logic [31:0] exp_addr;
        int lat;
        mvec_m = 32'h8000_0100;
        marg_m = 32'h0000_00A5;
        sb.push_back('{vec: 32'h8000_0100, arg: 32'h0000_00A5});
        irq_valid_i = 1'b1;
        global_ie_i = 1'b1;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_comb_path: busy_o=%0b required 0 before the edge", busy_o);
        end
        for (int k = 1; k <= S + 3; k++) begin
            step();
            exp_rd   = (k == S + 1) || (k == S + 2);
            exp_addr = (k == S + 1) ? A_MVEC : (k == S + 2) ? A_MARG : 32'h0;
            checks++;
            if (busy_o !== 1'b1 || plic_rd_o !== exp_rd || plic_raddr_o !== exp_addr
                || irq_req_o !== (k == S + 3)) begin
                failures++;
                $display("FAIL basic_seq cyc%0d: busy=%0b rd=%0b addr=%h req=%0b required 1 %0b %h %0b",
                         k, busy_o, plic_rd_o, plic_raddr_o, irq_req_o, exp_rd, exp_addr, k == S + 3);
            end
        end
        wait_req(0, lat);
        // Request held without ack: outputs stay stable.
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (irq_req_o !== 1'b1 || irq_vec_o !== 32'h8000_0100) begin
                failures++;
                $display("FAIL basic_hold: req=%0b vec=%h required 1 80000100", irq_req_o, irq_vec_o);
            end
        end
        irq_ack_i = 1'b1;
        exp_taken++;
        step();
        irq_ack_i = 1'b0;
        checks++;
        if (irq_req_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL basic_ack: req=%0b busy=%0b required 0 1", irq_req_o, busy_o);
        end
        // SERVICE ignores the still-asserted source.
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (busy_o !== 1'b1 || irq_req_o !== 1'b0 || plic_rd_o !== 1'b0) begin
                failures++;
                $display("FAIL basic_service: busy=%0b req=%0b rd=%0b required 1 0 0", busy_o, irq_req_o, plic_rd_o);
            end
        end
        irq_valid_i = 1'b0;
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_mret: busy_o=%0b required 0", busy_o);
        end
    endtask

    task automatic test_spurious();
        irq_valid_i = 1'b1;
        global_ie_i = 1'b1;
        step(); step();
        irq_valid_i = 1'b0;
        exp_spur++;
        step();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (busy_o !== 1'b0 || plic_rd_o !== 1'b0 || irq_req_o !== 1'b0) begin
                failures++;
                $display("FAIL spurious cyc%0d: busy=%0b rd=%0b req=%0b required 0 0 0", k, busy_o, plic_rd_o, irq_req_o);
            end
            step();
        end
`ifdef PLIC_DISPATCH_STATS_EN
        checks++;
        if (stat_spurious_o !== 16'(exp_spur)) begin
            failures++;
            $display("FAIL spurious_stat: got %0d required %0d", stat_spurious_o, exp_spur);
        end
`endif
    endtask

    task automatic test_masked();
        irq_valid_i = 1'b1;
        global_ie_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (busy_o !== 1'b0) begin
                failures++;
                $display("FAIL masked cyc%0d: busy_o=%0b required 0", k, busy_o);
            end
        end
        irq_valid_i = 1'b0;
        global_ie_i = 1'b1;
        step();
    endtask

    task automatic test_withdraw();
        run_to_req(32'h8000_0300, 32'h0000_0011);
        irq_valid_i = 1'b0;
        step();
        checks++;
        if (irq_req_o !== 1'b1) begin
            failures++;
            $display("FAIL req_no_abort: irq_req_o=%0b required 1 after source drop", irq_req_o);
        end
        global_ie_i = 1'b0;
        step();
        checks++;
        if (irq_req_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL withdraw: req=%0b busy=%0b required 0 0", irq_req_o, busy_o);
        end
        global_ie_i = 1'b1;
        step();
        run_to_req(32'h8000_0400, 32'h0000_0022);
        irq_valid_i = 1'b0;
        global_ie_i = 1'b0;
        irq_ack_i = 1'b1;
        exp_taken++;
        step();
        irq_ack_i = 1'b0;
        global_ie_i = 1'b1;
        checks++;
        if (irq_req_o !== 1'b0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL ack_wins: req=%0b busy=%0b required 0 1", irq_req_o, busy_o);
        end
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL ack_wins_mret: busy_o=%0b required 0", busy_o);
        end
    endtask

    task automatic test_redispatch();
        int lat;
        run_to_req(32'h8000_0100, 32'h0000_0033);
        // mret outside SERVICE must be ignored.
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        checks++;
        if (irq_req_o !== 1'b1) begin
            failures++;
            $display("FAIL mret_in_req: irq_req_o=%0b required 1", irq_req_o);
        end
        irq_ack_i = 1'b1;
        exp_taken++;
        step();
        irq_ack_i = 1'b0;
        mvec_m = 32'h8000_0200;
        marg_m = 32'h0000_0044;
        sb.push_back('{vec: 32'h8000_0200, arg: 32'h0000_0044});
        step();
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL redisp_idle: busy_o=%0b required 0", busy_o);
        end
        step();
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL redisp_settle: busy_o=%0b required 1", busy_o);
        end
        wait_req(S + 6, lat);
        checks++;
        if (lat != S + 2) begin
            failures++;
            $display("FAIL redisp_latency: got %0d required %0d", lat, S + 2);
        end
        irq_ack_i = 1'b1;
        exp_taken++;
        step();
        irq_ack_i = 1'b0;
        irq_valid_i = 1'b0;
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        // mret in IDLE: no state change, captured values unchanged.
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        step();
        checks++;
        if (busy_o !== 1'b0 || irq_req_o !== 1'b0 || irq_vec_o !== 32'h8000_0200 || irq_arg_o !== 32'h0000_0044) begin
            failures++;
            $display("FAIL mret_in_idle: busy=%0b req=%0b vec=%h arg=%h required 0 0 80000200 00000044",
                     busy_o, irq_req_o, irq_vec_o, irq_arg_o);
        end
`ifdef PLIC_DISPATCH_STATS_EN
        checks++;
        if (stat_taken_o !== 16'(exp_taken)) begin
            failures++;
            $display("FAIL taken_stat: got %0d required %0d", stat_taken_o, exp_taken);
        end
`endif
    endtask

    task automatic test_reset_mid();
        run_to_req(32'h8000_0500, 32'h0000_0055);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (irq_req_o !== 1'b0 || irq_vec_o !== 32'h0 || irq_arg_o !== 32'h0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: req=%0b vec=%h arg=%h busy=%0b required 0 0 0 0",
                     irq_req_o, irq_vec_o, irq_arg_o, busy_o);
        end
        irq_valid_i = 1'b0;
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (irq_req_o !== 1'b0 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_release cyc%0d: req=%0b busy=%0b required 0 0", k, irq_req_o, busy_o);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_spurious();
        test_masked();
        test_withdraw();
        test_redispatch();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d expected dispatches never seen, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
